// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and defaults for the multiply/divide unit.
package mdu_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MUL_LAT = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MADDU = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative restoring divider on unsigned magnitudes.
// One quotient bit per step; load primes the dividend, divisor and partial remainder.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Shift-subtract step: keep the difference only when it does not go negative.
  // The quotient register doubles as the dividend shift register.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit owning the HI/LO pair.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU (ops 110/111);
// without it those ops are silently ignored.
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO write HI/LO here
// MUL   | multiply latency countdown, product written on terminal count
// DIV   | one restoring-division step per cycle
// FIX   | sign correction, divide-by-zero override, HI/LO write-back
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  op_e                op_in;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               div_load, div_step;
  logic               div_signed_in;
  logic [WIDTH-1:0]   div_a, div_b;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic               q_neg, r_neg;

  logic               mul_signed, is_madd;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc_sum;

  assign op_in = op_e'(op);

  // Operand magnitudes for the divider, taken straight from the inputs on the accepting edge.
  always_comb begin
    div_signed_in = (op_in == OP_DIV);
    div_a = (div_signed_in && a[WIDTH-1]) ? -a : a;
    div_b = (div_signed_in && b[WIDTH-1]) ? -b : b;
  end

  // Product and optional accumulate, evaluated from the latched operands.
  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD);
    is_madd    = (op_q == OP_MADD) || (op_q == OP_MADDU);
    a_ext   = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext   = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod    = a_ext * b_ext;
    acc_sum = is_madd ? ({hi_q, lo_q} + prod) : prod;
    q_neg   = (op_q == OP_DIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg   = (op_q == OP_DIV) && a_q[WIDTH-1];
  end

  // Next-state, counter and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_in)
            OP_MULT, OP_MULTU: begin
              state_d = ST_MUL;
              cnt_d   = MUL_LOAD;
              op_d    = op_in;
              a_d     = a;
              b_d     = b;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              state_d = ST_MUL;
              cnt_d   = MUL_LOAD;
              op_d    = op_in;
              a_d     = a;
              b_d     = b;
            end
`endif
            OP_DIV, OP_DIVU: begin
              state_d  = ST_DIV;
              cnt_d    = DIV_LOAD;
              op_d     = op_in;
              a_d      = a;
              b_d      = b;
              div_load = 1'b1;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = acc_sum;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIX: begin
        // Zero divisor gets a fixed result rather than whatever the core produced.
        if (b_q == '0) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = q_neg ? -div_quo : div_quo;
          hi_d = r_neg ? -div_rem : div_rem;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and architectural registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  mdu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (div_a),
    .divisor  (div_b),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed vector table plus hand sequences for mdu_seq.
// Expectations follow MDU_MADD_EN the same way the design build does.
module tb_mdu_seq;

`ifdef MDU_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DB = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    int           ebusy;
    logic         edone;
  } vec_t;

  vec_t vecs[$];

  mdu_seq #(
    .WIDTH  (W),
    .MUL_LAT(ML)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic [W-1:0] ehi, input logic [W-1:0] elo,
                              input int eb, input logic ed);
    vec_t v;
    v.op = o; v.a = av; v.b = bv; v.ehi = ehi; v.elo = elo; v.ebusy = eb; v.edone = ed;
    vecs.push_back(v);
  endfunction

  // Present one request, scramble the inputs after acceptance, count busy cycles.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int nbusy, output logic dn);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b101; a = $urandom; b = $urandom;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 200) begin
      nbusy++;
      @(posedge clk); #1;
    end
    dn = done;
  endtask

  initial begin
    int nb;
    logic dn;
    logic hold_ok;

    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;

    add(3'b000, 32'hFFFFFFFE, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFC, ML, 1'b1);
    add(3'b001, 32'hFFFFFFFE, 32'd2,        32'h00000001, 32'hFFFFFFFC, ML, 1'b1);
    add(3'b000, 32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4, ML, 1'b1);
    add(3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, ML, 1'b1);
    add(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, ML, 1'b1);
    add(3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DB, 1'b1);
    add(3'b011, 32'd7,        32'd2,        32'h00000001, 32'h00000003, DB, 1'b1);
    add(3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DB, 1'b1);
    add(3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, DB, 1'b1);
    add(3'b011, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, DB, 1'b1);
    add(3'b011, 32'd3,        32'd10,       32'h00000003, 32'h00000000, DB, 1'b1);
    add(3'b010, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, DB, 1'b1);
    add(3'b010, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, DB, 1'b1);
    add(3'b011, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, DB, 1'b1);
    add(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DB, 1'b1);
    add(3'b100, 32'hDEADBEEF, 32'd9,        32'hDEADBEEF, 32'h80000000, 0,  1'b0);
    add(3'b101, 32'h00000055, 32'd9,        32'hDEADBEEF, 32'h00000055, 0,  1'b0);
    add(3'b100, 32'h00000000, 32'd0,        32'h00000000, 32'h00000055, 0,  1'b0);
    add(3'b101, 32'h00000001, 32'd0,        32'h00000000, 32'h00000001, 0,  1'b0);
    add(3'b110, 32'd3,        32'd4,        32'h00000000, MADD_ON ? 32'd13 : 32'd1,
        MADD_ON ? ML : 0, MADD_ON);
    add(3'b101, 32'hFFFFFFFF, 32'd0,        32'h00000000, 32'hFFFFFFFF, 0,  1'b0);
    add(3'b111, 32'd1,        32'd1,        MADD_ON ? 32'd1 : 32'd0,
        MADD_ON ? 32'd0 : 32'hFFFFFFFF, MADD_ON ? ML : 0, MADD_ON);
    add(3'b110, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF,
        MADD_ON ? ML : 0, MADD_ON);

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, nb, dn);
      check($sformatf("v%0d_busy_cycles", i), 64'(nb), 64'(vecs[i].ebusy));
      check($sformatf("v%0d_done", i), {63'd0, dn}, {63'd0, vecs[i].edone});
      check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].ehi});
      check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].elo});
      @(posedge clk); #1;
      check($sformatf("v%0d_done_drop", i), {63'd0, done}, 64'd0);
    end

    // MTLO held during a multiply must be ignored; HI/LO hold until completion.
    issue(3'b100, 32'h1234, 32'd0, nb, dn);
    check("seq_mthi", {32'd0, hi}, 64'h1234);
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    op = 3'b101; a = 32'hBAD; b = 32'd0;
    nb = 0;
    hold_ok = 1'b1;
    while (busy === 1'b1 && nb < 200) begin
      if (hi !== 32'h1234 || lo !== 32'hFFFFFFFF) hold_ok = 1'b0;
      nb++;
      @(posedge clk); #1;
    end
    check("seq_mul_busy", 64'(nb), 64'(ML));
    check("seq_hold_hilo", {63'd0, hold_ok}, 64'd1);
    check("seq_mul_done", {63'd0, done}, 64'd1);
    check("seq_mul_hi", {32'd0, hi}, 64'd0);
    check("seq_mul_lo", {32'd0, lo}, 64'd12);
    // Back-to-back DIVU presented while done is high.
    op = 3'b011; a = 32'd9; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; a = 32'd0; b = 32'd0;
    check("b2b_accept", {63'd0, busy}, 64'd1);
    check("b2b_lo_kept", {32'd0, lo}, 64'd12);
    nb = 0;
    while (busy === 1'b1 && nb < 200) begin
      nb++;
      @(posedge clk); #1;
    end
    check("b2b_busy", 64'(nb), 64'(DB));
    check("b2b_done", {63'd0, done}, 64'd1);
    check("b2b_hi", {32'd0, hi}, 64'd1);
    check("b2b_lo", {32'd0, lo}, 64'd2);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b010, 32'hFFFFFF9C, 32'd7, nb, dn);
    check("post_busy", 64'(nb), 64'(DB));
    check("post_done", {63'd0, dn}, 64'd1);
    check("post_hi", {32'd0, hi}, 64'hFFFFFFFE);
    check("post_lo", {32'd0, lo}, 64'hFFFFFFF2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
